// File: rtl/sb_tx_serializer.sv
// rtl/sb_tx_serializer.sv - sideband transmit serializer: message FIFO, MSB-first shifter, forwarded clock
module sb_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_UI     = 32
) (
    input  logic                          clk_800MHz,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic [63:0]                   data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          dataPin_o,
    output logic                          clkPin_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2((GAP_UI > 64) ? GAP_UI : 64);
    localparam logic [CW-1:0] SEND_LAST = CW'(63);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_UI - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    state_t        state, state_nxt;
    logic          phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [63:0]   shift_reg, shift_nxt;
    logic          clk_nxt;
    logic          data_nxt;
    logic          start;

    assign ready_o      = (count != (AW+1)'(FIFO_DEPTH));
    assign push         = valid_i && ready_o;
    assign head         = mem[rd_ptr];
    assign fifo_count_o = count;
    assign busy_o       = (state != IDLE);
    assign start        = enable_i && (count != '0);

    // Storage has no reset so it can map onto a plain register file.
    always_ff @(posedge clk_800MHz) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Pin values are computed one cycle ahead so clkPin_o/dataPin_o come straight from flops.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        shift_nxt = shift_reg;
        clk_nxt   = clkPin_o;
        data_nxt  = dataPin_o;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                clk_nxt  = 1'b0;
                data_nxt = 1'b0;
                if (start) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    cnt_nxt   = '0;
                    phase_nxt = 1'b0;
                    state_nxt = SEND;
                    clk_nxt   = 1'b1;
                    data_nxt  = head[63];
                end
            end
            SEND: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                    clk_nxt   = 1'b0;
                end else begin
                    phase_nxt = 1'b0;
                    clk_nxt   = 1'b1;
                    if (cnt == SEND_LAST) begin
                        state_nxt = GAP;
                        cnt_nxt   = '0;
                        data_nxt  = 1'b0;
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        shift_nxt = {shift_reg[62:0], 1'b0};
                        data_nxt  = shift_reg[62];
                    end
                end
            end
            GAP: begin
                data_nxt = 1'b0;
                if (!phase) begin
                    phase_nxt = 1'b1;
                    clk_nxt   = 1'b0;
                end else if (cnt != GAP_LAST) begin
                    phase_nxt = 1'b0;
                    clk_nxt   = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                end else if (start) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    cnt_nxt   = '0;
                    phase_nxt = 1'b0;
                    state_nxt = SEND;
                    clk_nxt   = 1'b1;
                    data_nxt  = head[63];
                end else begin
                    phase_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    clk_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                clk_nxt   = 1'b0;
                data_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 1'b0;
            cnt       <= '0;
            shift_reg <= '0;
            clkPin_o  <= 1'b0;
            dataPin_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            shift_reg <= shift_nxt;
            clkPin_o  <= clk_nxt;
            dataPin_o <= data_nxt;
        end
    end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// tb/tb_sb_tx_serializer.sv - directed bench for sb_tx_serializer with a falling-edge receiver model
`timescale 1ns/1ps
module tb_sb_tx_serializer;

    logic        clk_800MHz = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        dataPin_o;
    logic        clkPin_o;
    logic        busy_o;
    logic [2:0]  fifo_count_o;

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] rx_q [$];
    logic [63:0] rx_sh;
    int          ui_idx;
    int          fe_total;
    int          gap_err;
    logic [63:0] msgs [8];

    sb_tx_serializer dut (
        .clk_800MHz   (clk_800MHz),
        .reset        (reset),
        .enable_i     (enable_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .dataPin_o    (dataPin_o),
        .clkPin_o     (clkPin_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    always #1 clk_800MHz = ~clk_800MHz;

    // Receiver: 96 UIs per frame from reset, first 64 carry data MSB first.
    always @(negedge clkPin_o or posedge reset) begin
        if (reset) begin
            rx_q.delete();
            rx_sh    = '0;
            ui_idx   = 0;
            fe_total = 0;
            gap_err  = 0;
        end else begin
            fe_total = fe_total + 1;
            if (ui_idx < 64) begin
                rx_sh = {rx_sh[62:0], dataPin_o};
                if (ui_idx == 63) rx_q.push_back(rx_sh);
            end else if (dataPin_o) begin
                gap_err = gap_err + 1;
            end
            ui_idx = (ui_idx == 95) ? 0 : ui_idx + 1;
        end
    end

    task automatic do_reset();
        enable_i = 1'b0;
        valid_i  = 1'b0;
        @(negedge clk_800MHz);
        reset = 1'b1;
        repeat (3) @(negedge clk_800MHz);
        reset = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_800MHz);
    endtask

    task automatic push(input logic [63:0] d);
        int t = 0;
        @(negedge clk_800MHz);
        data_i  = d;
        valid_i = 1'b1;
        while (!ready_o && t < 5000) begin
            @(negedge clk_800MHz);
            t++;
        end
        n_cmp++;
        if (t >= 5000) begin
            n_fail++;
            $display("FAIL push_timeout: ready_o stayed %0b, required 1", ready_o);
        end
        @(posedge clk_800MHz);
    endtask

    task automatic wait_fe(input int target);
        int t = 0;
        while (fe_total < target && t < 2000) begin
            @(negedge clk_800MHz);
            t++;
        end
        n_cmp++;
        if (fe_total < target) begin
            n_fail++;
            $display("FAIL wait_fe: got %0d falling edges, required %0d", fe_total, target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_800MHz);
        reset = 1'b1;
        #0.2;
        n_cmp += 5;
        if (dataPin_o !== 1'b0)    begin n_fail++; $display("FAIL rst_data: got %b, required 0", dataPin_o); end
        if (clkPin_o !== 1'b0)     begin n_fail++; $display("FAIL rst_clk: got %b, required 0", clkPin_o); end
        if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
        if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", fifo_count_o); end
        repeat (2) @(negedge clk_800MHz);
        reset = 1'b0;
        @(negedge clk_800MHz);
        if (ready_o !== 1'b1)      begin n_fail++; $display("FAIL rst_ready: got %b, required 1", ready_o); end
    endtask

    task automatic test_single();
        int t = 0;
        int cyc = 0;
        do_reset();
        enable_i = 1'b1;
        push(64'hA5A5_0000_FFFF_1234);
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        while (clkPin_o !== 1'b1 && t < 20) begin
            @(negedge clk_800MHz);
            t++;
        end
        while (busy_o === 1'b1 && cyc < 400) begin
            @(negedge clk_800MHz);
            cyc++;
        end
        n_cmp += 5;
        if (cyc != 192) begin n_fail++; $display("FAIL single_len: busy for %0d cycles, required 192", cyc); end
        if (rx_q.size() != 1) begin
            n_fail++; $display("FAIL single_cnt: got %0d words, required 1", rx_q.size());
        end else if (rx_q[0] !== 64'hA5A5_0000_FFFF_1234) begin
            n_fail++; $display("FAIL single_word: got %h, required a5a50000ffff1234", rx_q[0]);
        end
        if (fe_total != 96) begin n_fail++; $display("FAIL single_pulses: got %0d, required 96", fe_total); end
        if (gap_err != 0)   begin n_fail++; $display("FAIL single_gap: %0d high gap samples, required 0", gap_err); end
        if (clkPin_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_clk: got %b, required 0", clkPin_o); end
    endtask

    task automatic test_back_to_back();
        int busy_low = 0;
        do_reset();
        @(negedge clk_800MHz); data_i = msgs[0]; valid_i = 1'b1;
        @(negedge clk_800MHz); data_i = msgs[1];
        @(negedge clk_800MHz); data_i = msgs[2];
        @(negedge clk_800MHz); valid_i = 1'b0;
        n_cmp++;
        if (fifo_count_o !== 3'd3) begin n_fail++; $display("FAIL b2b_fill: got %0d, required 3", fifo_count_o); end
        enable_i = 1'b1;
        for (int n = 1; n <= 577; n++) begin
            @(negedge clk_800MHz);
            if (n == 1 || n == 193 || n == 385) begin
                n_cmp++;
                if (fifo_count_o !== 3'(2 - (n - 1) / 192)) begin
                    n_fail++;
                    $display("FAIL b2b_count@%0d: got %0d, required %0d", n, fifo_count_o, 2 - (n - 1) / 192);
                end
            end
            if (n <= 576 && busy_o !== 1'b1) busy_low++;
            if (n == 577) begin
                n_cmp++;
                if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b, required 0", busy_o); end
            end
        end
        n_cmp += 3;
        if (busy_low != 0)   begin n_fail++; $display("FAIL b2b_idle: %0d idle cycles, required 0", busy_low); end
        if (fe_total != 288) begin n_fail++; $display("FAIL b2b_pulses: got %0d, required 288", fe_total); end
        if (rx_q.size() != 3) begin
            n_fail++; $display("FAIL b2b_words: got %0d, required 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rx_q[i] !== msgs[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h, required %h", i, rx_q[i], msgs[i]); end
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_800MHz);
            if (i == 4) begin
                n_cmp += 2;
                if (ready_o !== 1'b0)      begin n_fail++; $display("FAIL full_ready: got %b, required 0", ready_o); end
                if (fifo_count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d, required 4", fifo_count_o); end
            end
            data_i  = msgs[i];
            valid_i = 1'b1;
        end
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        n_cmp++;
        if (fifo_count_o !== 3'd4) begin n_fail++; $display("FAIL full_drop: got %0d, required 4", fifo_count_o); end
        enable_i = 1'b1;
        wait_cycles(4 * 192 + 20);
        n_cmp += 2;
        if (fe_total != 384) begin n_fail++; $display("FAIL full_pulses: got %0d, required 384", fe_total); end
        if (rx_q.size() != 4) begin
            n_fail++; $display("FAIL full_words: got %0d, required 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rx_q[i] !== msgs[i]) begin n_fail++; $display("FAIL full_word%0d: got %h, required %h", i, rx_q[i], msgs[i]); end
            end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable_i = 1'b1;
        push(msgs[5]);
        push(msgs[6]);
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        wait_fe(20);
        enable_i = 1'b0;
        wait_cycles(300);
        n_cmp += 4;
        if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL drop_busy: got %b, required 0", busy_o); end
        if (fifo_count_o !== 3'd1) begin n_fail++; $display("FAIL drop_count: got %0d, required 1", fifo_count_o); end
        if (fe_total != 96)        begin n_fail++; $display("FAIL drop_pulses: got %0d, required 96", fe_total); end
        if (rx_q.size() != 1 || rx_q[0] !== msgs[5]) begin
            n_fail++; $display("FAIL drop_first: got %0d words, required 1 word %h", rx_q.size(), msgs[5]);
        end
        enable_i = 1'b1;
        wait_cycles(250);
        n_cmp++;
        if (rx_q.size() != 2 || rx_q[1] !== msgs[6]) begin
            n_fail++; $display("FAIL drop_second: got %0d words, required 2 ending %h", rx_q.size(), msgs[6]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable_i = 1'b1;
        push(msgs[3]);
        push(msgs[4]);
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        wait_fe(40);
        @(posedge clk_800MHz);
        #0.3;
        reset = 1'b1;
        #0.2;
        n_cmp += 4;
        if (clkPin_o !== 1'b0)     begin n_fail++; $display("FAIL rmid_clk: got %b, required 0", clkPin_o); end
        if (dataPin_o !== 1'b0)    begin n_fail++; $display("FAIL rmid_data: got %b, required 0", dataPin_o); end
        if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d, required 0", fifo_count_o); end
        if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", busy_o); end
        @(negedge clk_800MHz);
        reset = 1'b0;
        wait_cycles(300);
        n_cmp += 2;
        if (fe_total != 0)    begin n_fail++; $display("FAIL rmid_residual: got %0d pulses, required 0", fe_total); end
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL rmid_words: got %0d words, required 0", rx_q.size()); end
    endtask

    task automatic test_loopback();
        logic [63:0] exp_w [8];
        do_reset();
        enable_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_w[i] = {$urandom(), $urandom()};
            push(exp_w[i]);
        end
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        wait_cycles(8 * 192 + 50);
        n_cmp += 2;
        if (gap_err != 0) begin n_fail++; $display("FAIL loop_gap: %0d high gap samples, required 0", gap_err); end
        if (rx_q.size() != 8) begin
            n_fail++; $display("FAIL loop_words: got %0d, required 8", rx_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL loop_word%0d: got %h, required %h", i, rx_q[i], exp_w[i]); end
            end
        end
    endtask

    initial begin
        msgs[0] = 64'h0123_4567_89AB_CDEF;
        msgs[1] = 64'hFFFF_FFFF_0000_0001;
        msgs[2] = 64'h8000_0000_0000_0000;
        msgs[3] = 64'hDEAD_BEEF_CAFE_F00D;
        msgs[4] = 64'h5555_AAAA_3333_CCCC;
        msgs[5] = 64'hC3C3_3C3C_0F0F_F0F0;
        msgs[6] = 64'h0000_0000_0000_0003;
        msgs[7] = 64'h1111_2222_4444_8888;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_enable_drop();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
